// File: rtl/lock_pkg.sv
// Shared types and key codes for the keypad door lock.
// Key codes 0-9 are digits; 10 and 11 are the '*' and '#' keys.
package lock_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t KEY_STAR = 4'd10;
  localparam digit_t KEY_HASH = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_CHG_OLD,
    S_CHG_NEW,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  function automatic logic is_digit(digit_t k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Keypad line decoder: one-hot to code, registered, with a press strobe
// on each no-key to key transition (two clocks after the key appears).
module keypad_decoder
  import lock_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] key_onehot,
  output logic        press,
  output digit_t      code
);

  logic   single;
  digit_t raw_code;
  logic   valid_q;
  logic   valid_d;
  logic   armed;
  digit_t code_q;

  assign single = (key_onehot != '0) &&
                  ((key_onehot & (key_onehot - 12'd1)) == '0);

  always_comb begin
    raw_code = '0;
    for (int i = 0; i < 12; i++) begin
      if (key_onehot[i]) raw_code = digit_t'(i);
    end
  end

  // armed stays low until a no-key sample is seen after reset,
  // so a key held across reset release never makes an event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      valid_d <= 1'b0;
      armed   <= 1'b0;
      code_q  <= '0;
      press   <= 1'b0;
      code    <= '0;
    end else begin
      valid_q <= single;
      code_q  <= single ? raw_code : '0;
      valid_d <= valid_q;
      armed   <= armed | ~single;
      press   <= valid_q & ~valid_d & armed;
      code    <= code_q;
    end
  end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad door lock: password entry, password change, timed open,
// failure counting with lockout, and abandonment of idle entries.
module keypad_lock_ctrl
  import lock_pkg::*;
#(
  parameter int PW_LEN      = 6,
  parameter logic [PW_LEN*4-1:0] INIT_PW = 24'h123456,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 1000,
  parameter int LOCK_CYCLES = 10000,
  parameter int IDLE_CYCLES = 5000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [11:0]                    key_onehot,
  output logic                           open,
  output logic                           alarm,
  output logic                           pw_updated,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output logic                           busy
);

  localparam int PW_W   = PW_LEN * 4;
  localparam int CNT_W  = $clog2(PW_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int T_AB   = (OPEN_CYCLES > LOCK_CYCLES) ?
                          OPEN_CYCLES : LOCK_CYCLES;
  localparam int T_MAX  = (T_AB > IDLE_CYCLES) ? T_AB : IDLE_CYCLES;
  localparam int TMR_W  = (T_MAX < 2) ? 1 : $clog2(T_MAX);

  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(PW_LEN);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  T_OPEN   = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  T_LOCK   = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  T_IDLE   = TMR_W'(IDLE_CYCLES - 1);

  logic   press;
  digit_t code;

  state_t            state_q, state_n;
  logic [TMR_W-1:0]  timer_q, timer_n;
  logic [PW_W-1:0]   entry_q, entry_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic [FAIL_W-1:0] fail_q, fail_n;
  logic [PW_W-1:0]   pw_q, pw_n;
  logic              upd_q, upd_n;
  logic              match;

  keypad_decoder u_dec (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_onehot (key_onehot),
    .press      (press),
    .code       (code)
  );

  assign match = (count_q == FULL) && (entry_q == pw_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      entry_q <= '0;
      count_q <= '0;
      fail_q  <= '0;
      pw_q    <= INIT_PW;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      entry_q <= entry_n;
      count_q <= count_n;
      fail_q  <= fail_n;
      pw_q    <= pw_n;
      upd_q   <= upd_n;
    end
  end

  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    entry_n = entry_q;
    count_n = count_q;
    fail_n  = fail_q;
    pw_n    = pw_q;
    upd_n   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          unique case (1'b1)
            is_digit(code): begin
              entry_n = '0;
              entry_n[PW_W-1 -: 4] = code;
              count_n = CNT_W'(1);
              timer_n = T_IDLE;
              state_n = S_ENTER;
            end
            (code == KEY_STAR): begin
              entry_n = '0;
              count_n = '0;
              timer_n = T_IDLE;
              state_n = S_CHG_OLD;
            end
            default: ;
          endcase
        end
      end
      S_ENTER, S_CHG_OLD, S_CHG_NEW: begin
        if (press) begin
          timer_n = T_IDLE;
          unique case (1'b1)
            is_digit(code): begin
              if (count_q < FULL) begin
                entry_n[(PW_LEN-1-int'(count_q))*4 +: 4] = code;
                count_n = count_q + 1'b1;
              end
            end
            (code == KEY_STAR): begin
              entry_n = '0;
              count_n = '0;
              timer_n = '0;
              state_n = S_IDLE;
            end
            (code == KEY_HASH): begin
              entry_n = '0;
              count_n = '0;
              timer_n = '0;
              state_n = S_IDLE;
              if (state_q == S_CHG_NEW) begin
                if (count_q == FULL) begin
                  pw_n  = entry_q;
                  upd_n = 1'b1;
                end
              end else if (match) begin
                fail_n = '0;
                if (state_q == S_ENTER) begin
                  state_n = S_OPEN;
                  timer_n = T_OPEN;
                end else begin
                  state_n = S_CHG_NEW;
                  timer_n = T_IDLE;
                end
              end else begin
                fail_n = fail_q + 1'b1;
                if (fail_n == FAIL_MAX) begin
                  state_n = S_LOCKOUT;
                  timer_n = T_LOCK;
                end
              end
            end
            default: ;
          endcase
        end else if (timer_q == '0) begin
          entry_n = '0;
          count_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer_q - 1'b1;
        end
      end
      S_OPEN: begin
        if (timer_q == '0) state_n = S_IDLE;
        else timer_n = timer_q - 1'b1;
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_n  = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer_q - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign open       = (state_q == S_OPEN);
  assign alarm      = (state_q == S_LOCKOUT);
  assign busy       = (state_q != S_IDLE);
  assign fail_cnt   = fail_q;
  assign pw_updated = upd_q;

endmodule
